// File: rtl/mips32_ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared MIPS32_RAM.
// slave = arbiter view, master = requesters plus RAM view.
interface mips32_ram_arbiter_if #(
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 32,
  parameter int LANES  = 4
) ();
  logic              reqA, reqB;
  logic              weA, weB;
  logic [AWIDTH-1:0] addrA, addrB;
  logic [DWIDTH-1:0] wdataA, wdataB;
  logic [LANES-1:0]  laneA, laneB;
  logic              ackA, ackB;
  logic [DWIDTH-1:0] rdataA, rdataB;
  logic              rvalidA, rvalidB;
  logic [AWIDTH-1:0] readAddr;
  logic              readEnable;
  logic [DWIDTH-1:0] readData;
  logic [AWIDTH-1:0] writeAddr;
  logic [DWIDTH-1:0] writeData;
  logic [LANES-1:0]  writeLane;
  logic              writeEnable;

  modport slave (
    input  reqA, reqB, weA, weB, addrA, addrB, wdataA, wdataB, laneA, laneB, readData,
    output ackA, ackB, rdataA, rdataB, rvalidA, rvalidB,
           readAddr, readEnable, writeAddr, writeData, writeLane, writeEnable
  );

  modport master (
    output reqA, reqB, weA, weB, addrA, addrB, wdataA, wdataB, laneA, laneB, readData,
    input  ackA, ackB, rdataA, rdataB, rvalidA, rvalidB,
           readAddr, readEnable, writeAddr, writeData, writeLane, writeEnable
  );
endinterface

// File: rtl/mips32_ram_arbiter.sv
// Two-port arbiter (A = fetch, B = load/store) in front of one MIPS32_RAM.
// Read and write channels are arbitrated independently; read data returns one cycle after grant.
module mips32_ram_arbiter #(
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 32,
  parameter int LANES  = 4,
  parameter int PRIO   = 0
) (
  input logic                   clock,
  input logic                   reset,
  mips32_ram_arbiter_if.slave   bus
);

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

  port_e            r_rd_last;
  port_e            r_wr_last;
  logic             r_rvalid_a;
  logic             r_rvalid_b;

  logic             w_rd_req_a, w_rd_req_b;
  logic             w_wr_req_a, w_wr_req_b;
  logic             w_rd_gnt_a, w_rd_gnt_b;
  logic             w_wr_gnt_a, w_wr_gnt_b;
  logic [LANES-1:0] w_lane_a, w_lane_b;

  // Returns {grant_b, grant_a}; on contention the port that was not last served wins,
  // unless fixed priority hands every tie to B.
  function automatic logic [1:0] arbitrate(input logic req_a, input logic req_b,
                                           input port_e last);
    if (req_a && req_b)
      return (PRIO == 1 || last == PORT_A) ? 2'b10 : 2'b01;
    return {req_b, req_a};
  endfunction

  assign w_rd_req_a = bus.reqA & ~bus.weA;
  assign w_rd_req_b = bus.reqB & ~bus.weB;
  assign w_wr_req_a = bus.reqA &  bus.weA;
  assign w_wr_req_b = bus.reqB &  bus.weB;

  assign {w_rd_gnt_b, w_rd_gnt_a} = arbitrate(w_rd_req_a, w_rd_req_b, r_rd_last);
  assign {w_wr_gnt_b, w_wr_gnt_a} = arbitrate(w_wr_req_a, w_wr_req_b, r_wr_last);

  assign w_lane_a = (LANES > 1) ? bus.laneA : '1;
  assign w_lane_b = (LANES > 1) ? bus.laneB : '1;

  // NOTE: every output gets a default before the if-chains so no latch is inferred.
  always_comb begin
    bus.readEnable  = w_rd_gnt_a | w_rd_gnt_b;
    bus.readAddr    = '0;
    bus.writeEnable = w_wr_gnt_a | w_wr_gnt_b;
    bus.writeAddr   = '0;
    bus.writeData   = '0;
    bus.writeLane   = '0;
    if (w_rd_gnt_a)      bus.readAddr = bus.addrA;
    else if (w_rd_gnt_b) bus.readAddr = bus.addrB;
    if (w_wr_gnt_a) begin
      bus.writeAddr = bus.addrA;
      bus.writeData = bus.wdataA;
      bus.writeLane = w_lane_a;
    end else if (w_wr_gnt_b) begin
      bus.writeAddr = bus.addrB;
      bus.writeData = bus.wdataB;
      bus.writeLane = w_lane_b;
    end
  end

  // Acks stay combinational during reset, so a request seen in the reset cycle still
  // reaches the RAM; only the registered state is cleared.
  assign bus.ackA    = w_rd_gnt_a | w_wr_gnt_a;
  assign bus.ackB    = w_rd_gnt_b | w_wr_gnt_b;
  assign bus.rdataA  = bus.readData;
  assign bus.rdataB  = bus.readData;
  assign bus.rvalidA = r_rvalid_a;
  assign bus.rvalidB = r_rvalid_b;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rd_last  <= PORT_B;  // "B served last" means A wins the next tie
      r_wr_last  <= PORT_B;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
    end else begin
      r_rvalid_a <= w_rd_gnt_a;
      r_rvalid_b <= w_rd_gnt_b;
      if (w_rd_gnt_a || w_rd_gnt_b) r_rd_last <= w_rd_gnt_b ? PORT_B : PORT_A;
      if (w_wr_gnt_a || w_wr_gnt_b) r_wr_last <= w_wr_gnt_b ? PORT_B : PORT_A;
    end
  end

endmodule

// File: tb/tb_mips32_ram_arbiter.sv
// Scoreboard bench: instance 0 uses round-robin, instance 1 fixed priority; each has its own RAM model.
// Reads push expected entries at issue; a separate monitor pops them on rvalid.
module tb_mips32_ram_arbiter;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  lane;
  } preq_t;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  addr;
  } rd_exp_t;

  localparam preq_t IDLE = '0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Per instance [g], per port [p] (0 = A, 1 = B)
  logic        rst_n  [2];
  logic        req    [2][2];
  logic        we     [2][2];
  logic [3:0]  addr   [2][2];
  logic [31:0] wdata  [2][2];
  logic [3:0]  lane   [2][2];
  logic        ack    [2][2];
  logic        rvalid [2][2];
  logic [31:0] rdata  [2][2];
  logic        re     [2];
  logic [3:0]  raddr  [2];
  logic        wen    [2];
  logic [3:0]  waddr  [2];
  logic [31:0] wdat   [2];
  logic [3:0]  wlane  [2];

  for (genvar g = 0; g < 2; g++) begin : u
    mips32_ram_arbiter_if #(.AWIDTH(4), .DWIDTH(32), .LANES(4)) bus ();

    mips32_ram_arbiter #(.AWIDTH(4), .DWIDTH(32), .LANES(4), .PRIO(g)) u_dut (
      .clock (clk),
      .reset (rst_n[g]),
      .bus   (bus)
    );

    assign bus.reqA   = req[g][0];
    assign bus.reqB   = req[g][1];
    assign bus.weA    = we[g][0];
    assign bus.weB    = we[g][1];
    assign bus.addrA  = addr[g][0];
    assign bus.addrB  = addr[g][1];
    assign bus.wdataA = wdata[g][0];
    assign bus.wdataB = wdata[g][1];
    assign bus.laneA  = lane[g][0];
    assign bus.laneB  = lane[g][1];
    assign ack[g][0]    = bus.ackA;
    assign ack[g][1]    = bus.ackB;
    assign rvalid[g][0] = bus.rvalidA;
    assign rvalid[g][1] = bus.rvalidB;
    assign rdata[g][0]  = bus.rdataA;
    assign rdata[g][1]  = bus.rdataB;
    assign re[g]    = bus.readEnable;
    assign raddr[g] = bus.readAddr;
    assign wen[g]   = bus.writeEnable;
    assign waddr[g] = bus.writeAddr;
    assign wdat[g]  = bus.writeData;
    assign wlane[g] = bus.writeLane;

    // MIPS32_RAM: registered read address held while idle, byte-lane writes, write bypass.
    logic [31:0] ram [16];
    logic [3:0]  ram_raddr;
    initial begin
      for (int i = 0; i < 16; i++) ram[i] = '0;
      ram_raddr = '0;
    end
    always @(posedge clk) begin
      if (bus.writeEnable)
        for (int l = 0; l < 4; l++)
          if (bus.writeLane[l]) ram[bus.writeAddr][8*l +: 8] <= bus.writeData[8*l +: 8];
      if (bus.readEnable) ram_raddr <= bus.readAddr;
    end
    assign bus.readData = (bus.writeEnable && bus.writeAddr == ram_raddr) ? bus.writeData
                                                                          : ram[ram_raddr];
  end

  // Reference model state
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;
  logic [31:0] m_mem     [2][16];
  logic        m_rd_fav_a[2];
  logic        m_wr_fav_a[2];
  logic        pend_v    [2];
  logic [3:0]  pend_addr [2];
  logic [31:0] pend_data [2];
  logic [3:0]  pend_lane [2];
  rd_exp_t     exp_q     [2][2][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic preq_t rd(input logic [3:0] a);
    preq_t r = IDLE;
    r.req = 1'b1; r.addr = a;
    return r;
  endfunction

  function automatic preq_t wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] l);
    preq_t r;
    r.req = 1'b1; r.we = 1'b1; r.addr = a; r.wdata = d; r.lane = l;
    return r;
  endfunction

  function automatic preq_t rand_req();
    preq_t r;
    r.req   = ($urandom_range(0, 3) != 0);
    r.we    = 1'($urandom_range(0, 1));
    r.addr  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
    r.wdata = $urandom;
    r.lane  = 4'($urandom_range(0, 15));
    return r;
  endfunction

  // Winner index for one channel: -1 none, 0 = A, 1 = B.
  function automatic int winner(input logic want_a, input logic want_b, input logic fav_a,
                                input int prio);
    if (want_a && want_b) return (prio == 1) ? 1 : (fav_a ? 0 : 1);
    if (want_a) return 0;
    if (want_b) return 1;
    return -1;
  endfunction

  // One clock cycle: instance g gets (pa, pb, rst_val); the other instance idles.
  task automatic step(input int g, input preq_t pa, input preq_t pb, input logic rst_val,
                      output logic ga, output logic gb);
    preq_t in [2];
    logic  rk;
    int    rw, ww;
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (pend_v[k])
        for (int l = 0; l < 4; l++)
          if (pend_lane[k][l]) m_mem[k][pend_addr[k]][8*l +: 8] = pend_data[k][8*l +: 8];
      pend_v[k] = 1'b0;
      in[0] = (k == g) ? pa : IDLE;
      in[1] = (k == g) ? pb : IDLE;
      rst_n[k] = (k == g) ? rst_val : 1'b1;
      for (int p = 0; p < 2; p++) begin
        req[k][p]   = in[p].req;
        we[k][p]    = in[p].we;
        addr[k][p]  = in[p].addr;
        wdata[k][p] = in[p].wdata;
        lane[k][p]  = in[p].lane;
      end
    end
    #1;
    ga = 1'b0;
    gb = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in[0] = (k == g) ? pa : IDLE;
      in[1] = (k == g) ? pb : IDLE;
      rk    = (k == g) ? rst_val : 1'b1;
      rw = winner(in[0].req & ~in[0].we, in[1].req & ~in[1].we, m_rd_fav_a[k], k);
      ww = winner(in[0].req &  in[0].we, in[1].req &  in[1].we, m_wr_fav_a[k], k);
      check($sformatf("i%0d ackA", k), 32'(ack[k][0]), 32'(rw == 0 || ww == 0));
      check($sformatf("i%0d ackB", k), 32'(ack[k][1]), 32'(rw == 1 || ww == 1));
      check($sformatf("i%0d readEnable", k), 32'(re[k]), 32'(rw >= 0));
      check($sformatf("i%0d readAddr", k), 32'(raddr[k]), (rw >= 0) ? 32'(in[rw].addr) : 32'd0);
      check($sformatf("i%0d writeEnable", k), 32'(wen[k]), 32'(ww >= 0));
      check($sformatf("i%0d writeAddr", k), 32'(waddr[k]), (ww >= 0) ? 32'(in[ww].addr) : 32'd0);
      check($sformatf("i%0d writeData", k), wdat[k], (ww >= 0) ? in[ww].wdata : 32'd0);
      check($sformatf("i%0d writeLane", k), 32'(wlane[k]), (ww >= 0) ? 32'(in[ww].lane) : 32'd0);
      if (rw >= 0 && rk) exp_q[k][rw].push_back('{cyc, in[rw].addr});
      if (ww >= 0) begin
        pend_v[k]    = 1'b1;
        pend_addr[k] = in[ww].addr;
        pend_data[k] = in[ww].wdata;
        pend_lane[k] = in[ww].lane;
      end
      if (!rk) begin
        m_rd_fav_a[k] = 1'b1;
        m_wr_fav_a[k] = 1'b1;
      end else begin
        if (rw >= 0) m_rd_fav_a[k] = (rw == 1);
        if (ww >= 0) m_wr_fav_a[k] = (ww == 1);
      end
      if (k == g) begin
        ga = (rw == 0 || ww == 0);
        gb = (rw == 1 || ww == 1);
      end
    end
  endtask

  // Monitor: rvalid must appear exactly the cycle after a read grant; data is the model
  // memory with this cycle's write bypassing as a full word.
  always @(negedge clk) begin
    rd_exp_t     e;
    logic        exp_v;
    logic [31:0] ev;
    #2;
    for (int g = 0; g < 2; g++)
      for (int p = 0; p < 2; p++) begin
        exp_v = (exp_q[g][p].size() > 0) && (exp_q[g][p][0].cyc == cyc - 1);
        check($sformatf("i%0d rvalid%s", g, p ? "B" : "A"), 32'(rvalid[g][p]), 32'(exp_v));
        if (exp_v) begin
          e  = exp_q[g][p].pop_front();
          ev = (pend_v[g] && pend_addr[g] == e.addr) ? pend_data[g] : m_mem[g][e.addr];
          check($sformatf("i%0d rdata%s@%0d", g, p ? "B" : "A", e.addr), rdata[g][p], ev);
        end
      end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic  ga, gb;
    preq_t cur [2];
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0;
      m_rd_fav_a[k] = 1'b1;
      m_wr_fav_a[k] = 1'b1;
      pend_v[k] = 1'b0;
      pend_addr[k] = '0;
      pend_data[k] = '0;
      pend_lane[k] = '0;
      for (int i = 0; i < 16; i++) m_mem[k][i] = '0;
      for (int p = 0; p < 2; p++) begin
        req[k][p] = 1'b0; we[k][p] = 1'b0; addr[k][p] = '0; wdata[k][p] = '0; lane[k][p] = '0;
      end
    end

    // Reset both instances for two cycles
    for (int i = 0; i < 2; i++) begin
      step(0, IDLE, IDLE, 1'b0, ga, gb);
      step(1, IDLE, IDLE, 1'b0, ga, gb);
    end

    // Write then read on port B
    step(0, IDLE, wr(4'd3, 32'hDEADBEEF, 4'hF), 1'b1, ga, gb);
    check("t1 write ackB", 32'(ack[0][1]), 32'd1);
    step(0, IDLE, rd(4'd3), 1'b1, ga, gb);
    check("t1 read ackB", 32'(ack[0][1]), 32'd1);
    step(0, IDLE, IDLE, 1'b1, ga, gb);
    check("t1 rvalidB", 32'(rvalid[0][1]), 32'd1);
    check("t1 rdataB", rdata[0][1], 32'hDEADBEEF);

    // Byte-lane merge on port A
    step(0, IDLE, wr(4'd5, 32'h11223344, 4'hF), 1'b1, ga, gb);
    step(0, wr(4'd5, 32'hAABBCCDD, 4'h6), IDLE, 1'b1, ga, gb);
    step(0, rd(4'd5), IDLE, 1'b1, ga, gb);
    step(0, IDLE, IDLE, 1'b1, ga, gb);
    check("t2 rdataA lanes", rdata[0][0], 32'h11BBCC44);

    // Read contention under round-robin, starting A-favoured after reset
    step(0, IDLE, wr(4'd1, 32'hA1A1A1A1, 4'hF), 1'b1, ga, gb);
    step(0, IDLE, wr(4'd2, 32'hB2B2B2B2, 4'hF), 1'b1, ga, gb);
    step(0, IDLE, IDLE, 1'b0, ga, gb);
    for (int i = 0; i < 6; i++) begin
      step(0, rd(4'd1), rd(4'd2), 1'b1, ga, gb);
      check($sformatf("t3 ackA #%0d", i), 32'(ack[0][0]), 32'(i % 2 == 0));
      check($sformatf("t3 ackB #%0d", i), 32'(ack[0][1]), 32'(i % 2 == 1));
    end
    step(0, IDLE, IDLE, 1'b1, ga, gb);
    check("t3 last rdataB", rdata[0][1], 32'hB2B2B2B2);

    // Parallel channels: A reads addr 7 while B writes it
    step(0, rd(4'd7), wr(4'd7, 32'h12345678, 4'hF), 1'b1, ga, gb);
    check("t4 ackA", 32'(ack[0][0]), 32'd1);
    check("t4 ackB", 32'(ack[0][1]), 32'd1);
    step(0, IDLE, IDLE, 1'b1, ga, gb);
    check("t4 rdataA", rdata[0][0], 32'h12345678);

    // Fixed priority instance: B always wins, A granted once B drops
    for (int i = 0; i < 4; i++) begin
      step(1, rd(4'd1), rd(4'd2), 1'b1, ga, gb);
      check($sformatf("t5 ackA #%0d", i), 32'(ack[1][0]), 32'd0);
      check($sformatf("t5 ackB #%0d", i), 32'(ack[1][1]), 32'd1);
    end
    step(1, rd(4'd1), IDLE, 1'b1, ga, gb);
    check("t5 ackA after B drops", 32'(ack[1][0]), 32'd1);

    // Reset mid-stream: read acked in reset cycle, no rvalid, pointer back to A
    step(0, rd(4'd4), IDLE, 1'b1, ga, gb);
    step(0, rd(4'd4), IDLE, 1'b0, ga, gb);
    check("t6 ackA in reset", 32'(ack[0][0]), 32'd1);
    step(0, rd(4'd1), rd(4'd2), 1'b1, ga, gb);
    check("t6 rvalidA after reset", 32'(rvalid[0][0]), 32'd0);
    check("t6 ackA first", 32'(ack[0][0]), 32'd1);
    check("t6 ackB waits", 32'(ack[0][1]), 32'd0);
    step(0, IDLE, rd(4'd2), 1'b1, ga, gb);

    // Randomized traffic with hold-until-ack requesters and rare resets
    for (int g = 0; g < 2; g++) begin
      cur[0] = rand_req();
      cur[1] = rand_req();
      for (int n = 0; n < 400; n++) begin
        step(g, cur[0], cur[1], ($urandom_range(0, 63) != 0), ga, gb);
        if (ga || !cur[0].req) cur[0] = rand_req();
        if (gb || !cur[1].req) cur[1] = rand_req();
      end
      step(g, IDLE, IDLE, 1'b1, ga, gb);
      step(g, IDLE, IDLE, 1'b1, ga, gb);
    end

    #2;
    for (int g = 0; g < 2; g++)
      for (int p = 0; p < 2; p++)
        check($sformatf("i%0d p%0d queue drained", g, p), 32'(exp_q[g][p].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
